// File: rtl/ex_stage_if.sv
// ----------------------------------------------------------------------------
// ex_stage_if
// Purpose : bundle carrying one EX-stage result towards the memory stage.
// Signals : inst      - instruction word
//           pc        - program counter of the instruction
//           ex_result - ALU result, or byte address for loads/stores
//           rw_en     - register write-back enable
//           rw_addr   - destination register index
//           lsu_data  - store data
//           lsu_op    - load/store operation code (4 bits)
// Modports: o - source side (EX stage), i - sink side (MEM stage)
// ----------------------------------------------------------------------------
interface ex_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           inst;
    logic [31:0]           pc;
    logic [DATA_WIDTH-1:0] ex_result;
    logic                  rw_en;
    logic [4:0]            rw_addr;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic [3:0]            lsu_op;

    modport o (
        output inst, pc, ex_result, rw_en, rw_addr, lsu_data, lsu_op
    );

    modport i (
        input  inst, pc, ex_result, rw_en, rw_addr, lsu_data, lsu_op
    );
endinterface

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// Purpose : memory-access pipeline stage. Accepts one EX result at a time,
//           runs a single-beat req/ack data-memory transaction for loads and
//           stores, and presents the aligned/extended write-back result to WB
//           from an output register.
// Ports   : clk, rst_n            - clock, synchronous active-low reset
//           ex (ex_stage_if.i)    - EX bundle; ex_valid / mem_ready handshake
//           dmem_req/we/addr/wstrb/wdata, dmem_ack/rdata - data-memory bus
//           wb_valid / wb_ready   - WB handshake
//           wb_pc, wb_inst, wb_rw_en, wb_rw_addr, wb_rw_data, wb_ale - WB bundle
// Config  : define MEM_ALIGN_CHECK_EN to flag misaligned halfword/word
//           accesses (wb_ale=1, no bus request). Without it wb_ale is tied 0
//           and low address bits are simply truncated.
// ----------------------------------------------------------------------------
module mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ex_stage_if.i                 ex,
    input  logic                  ex_valid,
    output logic                  mem_ready,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_wstrb,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [31:0]           wb_pc,
    output logic [31:0]           wb_inst,
    output logic                  wb_rw_en,
    output logic [4:0]            wb_rw_addr,
    output logic [DATA_WIDTH-1:0] wb_rw_data,
    output logic                  wb_ale
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    // access size encoding kept for the load extraction in BUSY
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t                  state_q;
    logic                    dmem_req_q;
    logic                    dmem_we_q;
    logic [ADDR_WIDTH-1:0]   dmem_addr_q;
    logic [3:0]              dmem_wstrb_q;
    logic [DATA_WIDTH-1:0]   dmem_wdata_q;
    logic                    wb_valid_q;
    logic [31:0]             wb_pc_q;
    logic [31:0]             wb_inst_q;
    logic                    wb_rw_en_q;
    logic [4:0]              wb_rw_addr_q;
    logic [DATA_WIDTH-1:0]   wb_rw_data_q;
    logic                    is_load_q;
    logic                    ld_unsigned_q;
    logic [1:0]              size_q;
    logic [1:0]              off_q;

    // ------------------------------------------------------------------
    // Decode of the incoming bundle (values loaded into the _q registers
    // on accept)
    // ------------------------------------------------------------------
    logic                    accept;
    logic                    is_load_d;
    logic                    is_store_d;
    logic                    ld_unsigned_d;
    logic [1:0]              size_d;
    logic [1:0]              off_d;
    logic [3:0]              wstrb_d;
    logic [DATA_WIDTH-1:0]   wdata_d;

    assign mem_ready = (state_q == IDLE) || ((state_q == HOLD) && wb_ready);
    assign accept    = ex_valid && mem_ready;
    assign off_d     = ex.ex_result[1:0];

    always_comb begin
        is_load_d     = 1'b0;
        is_store_d    = 1'b0;
        ld_unsigned_d = 1'b0;
        size_d        = SZ_W;
        wstrb_d       = 4'b0000;
        wdata_d       = '0;
        case (ex.lsu_op)
            4'b0001: begin is_load_d = 1'b1; size_d = SZ_B; end
            4'b0010: begin is_load_d = 1'b1; size_d = SZ_H; end
            4'b0011: begin is_load_d = 1'b1; size_d = SZ_W; end
            4'b0100: begin is_load_d = 1'b1; size_d = SZ_B; ld_unsigned_d = 1'b1; end
            4'b0101: begin is_load_d = 1'b1; size_d = SZ_H; ld_unsigned_d = 1'b1; end
            4'b1001: begin
                is_store_d = 1'b1;
                size_d     = SZ_B;
                wstrb_d    = 4'b0001 << off_d;
                wdata_d    = {4{ex.lsu_data[7:0]}};
            end
            4'b1010: begin
                is_store_d = 1'b1;
                size_d     = SZ_H;
                // off=3 shifts the upper lane out: truncation, not wrap
                wstrb_d    = 4'b0011 << off_d;
                wdata_d    = {2{ex.lsu_data[15:0]}};
            end
            4'b1011: begin
                is_store_d = 1'b1;
                size_d     = SZ_W;
                wstrb_d    = 4'b1111;
                wdata_d    = ex.lsu_data;
            end
            default: ; // every other code behaves as "none"
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_d;
    assign misalign_d = ((size_d == SZ_H) && off_d[0]) ||
                        ((size_d == SZ_W) && (off_d != 2'b00));
`endif

    // ------------------------------------------------------------------
    // Load data extraction from the returned word using the captured offset
    // ------------------------------------------------------------------
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;

    always_comb begin
        ld_byte = 8'h00;
        case (off_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            SZ_B:    ld_data = ld_unsigned_q ? {24'd0, ld_byte}
                                             : {{24{ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = ld_unsigned_q ? {16'd0, ld_half}
                                             : {{16{ld_half[15]}}, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_wstrb_q  <= 4'b0000;
            dmem_wdata_q  <= '0;
            wb_valid_q    <= 1'b0;
            wb_pc_q       <= '0;
            wb_inst_q     <= '0;
            wb_rw_en_q    <= 1'b0;
            wb_rw_addr_q  <= '0;
            wb_rw_data_q  <= '0;
            is_load_q     <= 1'b0;
            ld_unsigned_q <= 1'b0;
            size_q        <= SZ_B;
            off_q         <= 2'b00;
        end else if (accept) begin
            // Reachable from IDLE, or from HOLD when WB drains this cycle
            wb_pc_q       <= ex.pc;
            wb_inst_q     <= ex.inst;
            wb_rw_addr_q  <= ex.rw_addr;
            wb_rw_data_q  <= ex.ex_result;
            is_load_q     <= is_load_d;
            ld_unsigned_q <= ld_unsigned_d;
            size_q        <= size_d;
            off_q         <= off_d;
`ifdef MEM_ALIGN_CHECK_EN
            if ((is_load_d || is_store_d) && misalign_d) begin
                state_q      <= HOLD;
                wb_valid_q   <= 1'b1;
                wb_rw_en_q   <= 1'b0;
                dmem_req_q   <= 1'b0;
                dmem_we_q    <= 1'b0;
                dmem_wstrb_q <= 4'b0000;
            end else
`endif
            if (is_load_d || is_store_d) begin
                state_q      <= BUSY;
                wb_valid_q   <= 1'b0;
                wb_rw_en_q   <= ex.rw_en;
                dmem_req_q   <= 1'b1;
                dmem_we_q    <= is_store_d;
                dmem_addr_q  <= {ex.ex_result[ADDR_WIDTH-1:2], 2'b00};
                dmem_wstrb_q <= wstrb_d;
                dmem_wdata_q <= wdata_d;
            end else begin
                state_q      <= HOLD;
                wb_valid_q   <= 1'b1;
                wb_rw_en_q   <= ex.rw_en;
                dmem_req_q   <= 1'b0;
                dmem_we_q    <= 1'b0;
                dmem_wstrb_q <= 4'b0000;
            end
        end else begin
            case (state_q)
                BUSY: begin
                    if (dmem_ack) begin
                        state_q      <= HOLD;
                        wb_valid_q   <= 1'b1;
                        dmem_req_q   <= 1'b0;
                        dmem_we_q    <= 1'b0;
                        dmem_wstrb_q <= 4'b0000;
                        if (is_load_q) begin
                            wb_rw_data_q <= ld_data;
                        end else begin
                            wb_rw_en_q   <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (wb_ready) begin
                        state_q    <= IDLE;
                        wb_valid_q <= 1'b0;
                    end
                end
                default: ; // IDLE without accept: ack here is ignored
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic wb_ale_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_ale_q <= 1'b0;
        end else if (accept) begin
            wb_ale_q <= (is_load_d || is_store_d) && misalign_d;
        end
    end
    assign wb_ale = wb_ale_q;
`else
    assign wb_ale = 1'b0;
`endif

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wstrb = dmem_wstrb_q;
    assign dmem_wdata = dmem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_pc      = wb_pc_q;
    assign wb_inst    = wb_inst_q;
    assign wb_rw_en   = wb_rw_en_q;
    assign wb_rw_addr = wb_rw_addr_q;
    assign wb_rw_data = wb_rw_data_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage: sink side of the `ex_stage_if` bundle (`i` modport). It accepts one EX result at a time over a valid/ready handshake. For loads and stores it runs a single-beat req/ack transaction on the data-memory bus, then presents the aligned, extended write-back result to WB behind an output register. It sits between the EX stage and the WB stage and back-pressures EX while a memory access is outstanding.

## Interface
- `DATA_WIDTH`, 32: datapath width; only 32 is supported.
- `ADDR_WIDTH`, 32: byte address width.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `ex` input `ex_stage_if.i`: `inst`, `pc`, `ex_result` (address or ALU result), `rw_en`, `rw_addr`, `lsu_data` (store data), `lsu_op`.
- `ex_valid` input 1: `ex` bundle holds a valid instruction.
- `mem_ready` output 1: stage accepts the bundle this cycle.
- `dmem_req` output 1: bus request.
- `dmem_we` output 1: 1 = store.
- `dmem_addr` output ADDR_WIDTH: word-aligned address (`ex_result[31:2]`, 2'b00).
- `dmem_wstrb` output 4: byte enables; 0 for loads.
- `dmem_wdata` output 32: store data replicated into lanes.
- `dmem_ack` input 1: request completed; `dmem_rdata` valid this cycle.
- `dmem_rdata` input 32: load data word.
- `wb_valid` output 1: WB bundle valid.
- `wb_ready` input 1: WB consumes the bundle.
- `wb_pc`, `wb_inst` output 32: carried through.
- `wb_rw_en` output 1, `wb_rw_addr` output 5, `wb_rw_data` output 32: register write-back.
- `wb_ale` output 1: misaligned-access flag (see Configuration).

## Operation
- `lsu_op` encoding (4 bits):
  - 0000 none
  - 0001 LD_B, 0010 LD_H, 0011 LD_W, 0100 LD_BU, 0101 LD_HU
  - 1001 ST_B, 1010 ST_H, 1011 ST_W
  - Other codes are treated as none.
- FSM states: IDLE, BUSY, HOLD.
- IDLE:
  - `mem_ready`=1.
  - On accept with op none: capture the bundle, set `wb_rw_data`=`ex_result`, go to HOLD.
  - On accept with a load or store: capture the bundle and `ex_result[1:0]`, assert `dmem_req` from the next cycle, go to BUSY.
- BUSY:
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wstrb` and `dmem_wdata` are held stable until `dmem_ack`.
  - On `dmem_ack`, a load captures the extracted data into `wb_rw_data` and a store forces `wb_rw_en`=0. Go to HOLD.
  - `dmem_req` drops in the cycle after the ack.
- HOLD:
  - `wb_valid`=1 and the outputs are stable.
  - On `wb_ready`, go to IDLE, or accept a new bundle in the same cycle (`mem_ready`=`wb_ready` in HOLD).
- Store strobes:
  - ST_B: `4'b0001<<off`.
  - ST_H: `4'b0011<<off`.
  - ST_W: 4'b1111.
  - wdata: B = byte ×4, H = half ×2, W = as-is.
- Load extraction: select byte or half at `off`, then sign-extend (LD_B/LD_H) or zero-extend (LD_BU/LD_HU).
- `mem_ready`=0 in BUSY.

## Timing
- Reset values:
  - State IDLE.
  - `dmem_req`, `dmem_we`, `wb_valid`, `wb_rw_en`, `wb_ale` = 0.
  - `dmem_wstrb` = 0.
  - All data and address outputs = 0.
- Non-memory latency: accept at cycle N, `wb_valid` at N+1.
- Memory latency: accept at N, `dmem_req` at N+1, ack at cycle A ≥ N+1, `wb_valid` at A+1.
- A zero-wait ack (ack in the first request cycle) is legal.
- `dmem_ack` outside BUSY is ignored.
- Reset asserted mid-BUSY:
  - Returns to IDLE and drops `dmem_req` next edge.
  - A late ack is ignored.
- Back-to-back: HOLD with `wb_ready`=1 and `ex_valid`=1 sustains 1 instruction per cycle for non-memory ops.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - An accepted access is misaligned when it is a halfword with `off[0]`≠0 or a word with `off`≠0.
  - A misaligned access skips BUSY (no `dmem_req`) and goes directly to HOLD with `wb_ale`=1 and `wb_rw_en`=0.
- Undefined:
  - `wb_ale` is tied 0.
  - Address low bits are truncated per the strobe and extraction rules with no check.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with `ex_valid`=1 → `mem_ready`=1, `dmem_req`=0, `wb_valid`=0 after release.
- ALU pass-through: op none, `ex_result`=0x1234_5678, `rw_addr`=5, `wb_ready`=1 → `wb_valid` next cycle with `wb_rw_data`=0x1234_5678 and `wb_rw_addr`=5. Three consecutive ops give 3 consecutive valid cycles.
- LD_B at address 0x103, `dmem_rdata`=0x80FF_0000, ack after 3 wait cycles:
  - `dmem_addr`=0x100 held for 3 cycles.
  - `wb_rw_data`=0xFFFF_FF80.
  - Same access with LD_BU gives 0x0000_0080.
- ST_H at 0x202 with `lsu_data`=0xAAAA_BEEF → `dmem_we`=1, `dmem_wstrb`=4'b1100, `dmem_wdata`=0xBEEF_BEEF, `wb_rw_en`=0.
- Back-pressure: `wb_ready`=0 for 4 cycles in HOLD → outputs stable, `mem_ready`=0; accept resumes the cycle `wb_ready` rises.
- With `MEM_ALIGN_CHECK_EN`: LD_W at 0x102 → no `dmem_req`, `wb_ale`=1 next cycle, `wb_rw_en`=0.
